// File: rtl/maxpool_window_engine_if.sv
// Stream interface for the max-pooling engine: element input and result output.
interface maxpool_window_engine_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  // Engine side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // Producer/consumer side driving the engine.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/maxpool_window_engine.sv
// Streaming max-pool: folds each run of P*P accepted signed elements into one
// maximum and presents it on a one-deep valid/ready output register.
module maxpool_window_engine #(
  parameter int N = 16,
  parameter int P = 2
) (
  input  logic                    clk,
  input  logic                    master_rst,
  input  logic                    rst_m,
  maxpool_window_engine_if.slave  bus,
  output logic                    busy
);
  localparam int K  = P * P;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  logic [CW-1:0]       cnt;
  logic signed [N-1:0] max_q;
  logic signed [N-1:0] din;
  logic signed [N-1:0] nxt_max;
  logic                in_acc;
  logic                out_acc;
  logic                last;

  assign din  = $signed(bus.in_data);
  assign last = (cnt == CW'(K - 1));

  // Output slot frees up in the same cycle the consumer takes the pending result.
  assign bus.in_ready = master_rst && !rst_m && (!bus.out_valid || bus.out_ready);
  assign in_acc       = bus.in_valid && bus.in_ready;
  assign out_acc      = bus.out_valid && bus.out_ready;
  assign busy         = (cnt != '0);

  // First element of a window loads directly so negative windows are not floored at 0;
  // with K = 1 cnt is always 0, so the result is the element itself.
  always_comb begin
    nxt_max = max_q;
    if (cnt == '0)       nxt_max = din;
    else if (din > max_q) nxt_max = din;
  end

  // Window accumulation and result register.
  always_ff @(posedge clk) begin
    if (!master_rst) begin
      cnt          <= '0;
      max_q        <= '0;
      bus.out_data <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (rst_m) begin
        cnt   <= '0;
        max_q <= '0;
      end else if (in_acc) begin
        max_q <= nxt_max;
        cnt   <= last ? '0 : cnt + CW'(1);
      end
      // A completing window wins over a drain so back-to-back results have no bubble.
      if (in_acc && last) begin
        bus.out_data  <= nxt_max;
        bus.out_valid <= 1'b1;
      end else if (out_acc) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_maxpool_window_engine.sv
// Bench for the max-pool engine: directed scenarios followed by a random stream,
// all scored against a window-list model of the pooling behaviour.
module tb_maxpool_window_engine;
  localparam int N = 16;
  localparam int P = 2;
  localparam int K = P * P;

  logic clk = 1'b0;
  logic master_rst;
  logic rst_m;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  logic [N-1:0] win[$];
  logic [N-1:0] expq[$];

  always #5 clk = ~clk;

  maxpool_window_engine_if #(.N(N)) bus ();

  maxpool_window_engine #(.N(N), .P(P)) dut (
    .clk        (clk),
    .master_rst (master_rst),
    .rst_m      (rst_m),
    .bus        (bus),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, check just before the rising edge,
  // then advance the model to what the rising edge should do.
  task automatic cyc(input logic iv, input logic [N-1:0] d, input logic ordy,
                     input logic rm, input logic mr);
    logic [N-1:0] m;
    logic         ir;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    rst_m         = rm;
    master_rst    = mr;
    #4;
    ir = mr && !rm && (expq.size() == 0 || ordy);
    chk("out_valid", N'(bus.out_valid), N'(expq.size() != 0));
    if (expq.size() != 0) chk("out_data", bus.out_data, expq[0]);
    chk("busy", N'(busy), N'(win.size() != 0));
    chk("in_ready", N'(bus.in_ready), N'(ir));
    if (!mr) begin
      win.delete();
      expq.delete();
    end else begin
      if (expq.size() != 0 && ordy) void'(expq.pop_front());
      if (rm) win.delete();
      else if (iv && ir) begin
        win.push_back(d);
        if (win.size() == K) begin
          m = win[0];
          foreach (win[i]) if ($signed(win[i]) > $signed(m)) m = win[i];
          expq.push_back(m);
          win.delete();
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [N-1:0] d);
    cyc(1'b1, d, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    master_rst    = 1'b0;
    rst_m         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", N'(bus.out_valid), '0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_busy", N'(busy), '0);
    chk("rst_in_ready", N'(bus.in_ready), '0);

    // Positive mix
    send(N'(3)); send(-N'(7)); send(N'(12)); send(N'(5));
    chk("t1_max", bus.out_data, N'(12));
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("t1_pulse_done", N'(bus.out_valid), '0);

    // All negative: no zero floor
    send(-N'(8)); send(-N'(3)); send(-N'(20)); send(-N'(1));
    chk("t2_max", bus.out_data, 16'hFFFF);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Backpressure
    send(N'(4)); send(N'(4)); send(N'(4)); send(N'(9));
    repeat (3) cyc(1'b1, N'(50), 1'b0, 1'b0, 1'b1);
    chk("t3_hold", bus.out_data, N'(9));
    cyc(1'b1, N'(50), 1'b1, 1'b0, 1'b1);
    chk("t3_new_window", N'(busy), N'(1));
    send(N'(1)); send(N'(2)); send(N'(3));
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Back-to-back streaming
    send(N'(1)); send(N'(2)); send(N'(3)); send(N'(4));
    chk("t4_first", bus.out_data, N'(4));
    send(N'(10)); send(N'(0)); send(-N'(5)); send(N'(6));
    chk("t4_second", bus.out_data, N'(10));
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Abort mid-window
    send(N'(100)); send(N'(90));
    cyc(1'b1, N'(200), 1'b1, 1'b1, 1'b1);
    chk("t5_aborted", N'(busy), '0);
    send(N'(1)); send(N'(2)); send(N'(3)); send(N'(4));
    chk("t5_max", bus.out_data, N'(4));
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Reset mid-window
    send(N'(30)); send(N'(40));
    repeat (2) cyc(1'b1, N'(77), 1'b1, 1'b0, 1'b0);
    chk("t6_data_zero", bus.out_data, '0);
    chk("t6_busy_zero", N'(busy), '0);
    send(-N'(2)); send(-N'(9)); send(-N'(4)); send(-N'(3));
    chk("t6_max", bus.out_data, -N'(2));
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Random stream with gaps, backpressure, aborts and occasional resets
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), N'($urandom),
          1'($urandom_range(0, 9) < 7),
          1'($urandom_range(0, 49) == 0),
          1'($urandom_range(0, 199) != 0));
    end
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
